rs_decode_corrector: RTL and testbench

// - Output stage of the RS decoder, directly downstream of the decoder codeword buffer RAM (DpRam).
// - Reads one buffered codeword from the RAM read port and XORs error magnitudes from the Forney stage into the flagged symbols.
// - Emits the corrected codeword as a continuous one-symbol-per-clock stream with sop/eop/fail flags.

---
 rtl/rs_dec_pkg.sv | 24 ++
 rtl/rs_err_table.sv | 90 +++++++++
 rtl/rs_decode_corrector.sv | 154 +++++++++++++++
 tb/tb_rs_decode_corrector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_dec_pkg.sv
// Shared constants, error-table entry and FSM state type for the RS decoder output stage.
package rs_dec_pkg;

  localparam int unsigned SYM_W     = 8;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned MEM_DEPTH = 264;
  localparam int unsigned N         = 204;
  localparam int unsigned T         = 8;
  localparam int unsigned LOC_W     = 8;
  localparam int unsigned CNT_W     = $clog2(T + 1);

  typedef struct packed {
    logic             valid;
    logic [LOC_W-1:0] loc;
    logic [SYM_W-1:0] mag;
  } err_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rs_err_table.sv
// Double-banked error table: load bank fills from the Forney stage, active bank drives
// the per-symbol correction magnitude, delayed two cycles to line up with RAM data.
module rs_err_table
  import rs_dec_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [LOC_W-1:0] loc_i,
  input  logic [SYM_W-1:0] mag_i,
  input  logic             swap_i,
  input  logic             rd_vld_i,
  input  logic [LOC_W-1:0] idx_i,
  output logic [SYM_W-1:0] mag_o,
  output logic             act_fail_o
);

  err_entry_t       ld_q  [T];
  err_entry_t       ld_d  [T];
  err_entry_t       act_q [T];
  err_entry_t       act_d [T];
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic             ld_fail_q, ld_fail_d;
  logic             act_fail_q, act_fail_d;
  logic [SYM_W-1:0] mag_c, mag_s1_q, mag_s2_q;

  // Swap first, so a write in the swap cycle lands in the freshly emptied load bank.
  always_comb begin
    ld_d       = ld_q;
    act_d      = act_q;
    ld_cnt_d   = ld_cnt_q;
    ld_fail_d  = ld_fail_q;
    act_fail_d = act_fail_q;
    if (swap_i) begin
      act_d      = ld_q;
      act_fail_d = ld_fail_q;
      for (int unsigned k = 0; k < T; k++) ld_d[k] = '0;
      ld_cnt_d   = '0;
      ld_fail_d  = 1'b0;
    end
    if (wr_i) begin
      if ((loc_i >= LOC_W'(N)) || (ld_cnt_d == CNT_W'(T))) begin
        ld_fail_d = 1'b1;
      end else begin
        for (int unsigned k = 0; k < T; k++) begin
          if (ld_cnt_d == CNT_W'(k)) begin
            ld_d[k].valid = 1'b1;
            ld_d[k].loc   = loc_i;
            ld_d[k].mag   = mag_i;
          end
        end
        ld_cnt_d = ld_cnt_d + CNT_W'(1);
      end
    end
  end

  // Parallel compare of all active entries; duplicate locations accumulate by XOR.
  always_comb begin
    mag_c = '0;
    for (int unsigned k = 0; k < T; k++) begin
      if (act_q[k].valid && (act_q[k].loc == idx_i)) mag_c = mag_c ^ act_q[k].mag;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < T; k++) begin
        ld_q[k]  <= '0;
        act_q[k] <= '0;
      end
      ld_cnt_q   <= '0;
      ld_fail_q  <= 1'b0;
      act_fail_q <= 1'b0;
      mag_s1_q   <= '0;
      mag_s2_q   <= '0;
    end else begin
      ld_q       <= ld_d;
      act_q      <= act_d;
      ld_cnt_q   <= ld_cnt_d;
      ld_fail_q  <= ld_fail_d;
      act_fail_q <= act_fail_d;
      mag_s1_q   <= rd_vld_i ? mag_c : '0;
      mag_s2_q   <= mag_s1_q;
    end
  end

  assign mag_o      = mag_s2_q;
  assign act_fail_o = act_fail_q;

endmodule

// File: rtl/rs_decode_corrector.sv
// RS decoder output stage: reads a buffered codeword from the RAM, XORs in error
// magnitudes and streams the corrected symbols with sop/eop/fail flags.
module rs_decode_corrector
  import rs_dec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              err_wr,
  input  logic [LOC_W-1:0]  err_loc,
  input  logic [SYM_W-1:0]  err_mag,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              dec_fail,
  output logic              busy,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              rden,
  input  logic [SYM_W-1:0]  q,
  output logic              out_valid,
  output logic [SYM_W-1:0]  out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_fail
);

  state_e            state_q, state_d;
  logic [LOC_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rden_q, rden_d;
  logic              dfail_q, dfail_d;
  logic              start_acc_c, last_c, busy_d;
  logic              v1_q, sop1_q, eop1_q, fail1_q;
  logic              v2_q, sop2_q, eop2_q, fail2_q;
  logic              busy_q, out_valid_q, out_sop_q, out_eop_q, out_fail_q;
  logic [SYM_W-1:0]  out_data_q;
  logic [SYM_W-1:0]  mag_al;
  logic              act_fail;

  assign last_c = (idx_q == LOC_W'(N - 1));

  rs_err_table u_err_table (
    .clk_i      (clock),
    .rst_i      (reset),
    .wr_i       (err_wr),
    .loc_i      (err_loc),
    .mag_i      (err_mag),
    .swap_i     (start_acc_c),
    .rd_vld_i   (rden_q),
    .idx_i      (idx_q),
    .mag_o      (mag_al),
    .act_fail_o (act_fail)
  );

  // Next-state: read sequencing, address wrap and start acceptance.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    rden_d      = rden_q;
    dfail_d     = dfail_q;
    start_acc_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) start_acc_c = 1'b1;
      end
      ST_READ: begin
        idx_d  = idx_q + LOC_W'(1);
        addr_d = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
        if (last_c) begin
          if (start) begin
            start_acc_c = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            rden_d  = 1'b0;
            idx_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (start) start_acc_c = 1'b1;
        else if (!v1_q && !v2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_acc_c) begin
      state_d = ST_READ;
      idx_d   = '0;
      addr_d  = base_addr;
      rden_d  = 1'b1;
      dfail_d = dec_fail;
    end
    busy_d = (state_d != ST_IDLE) | rden_q | v1_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      rden_q  <= 1'b0;
      dfail_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rden_q  <= rden_d;
      dfail_q <= dfail_d;
      busy_q  <= busy_d;
    end
  end

  // Two flag stages matching RAM latency, then the registered output stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      sop1_q      <= 1'b0;
      eop1_q      <= 1'b0;
      fail1_q     <= 1'b0;
      v2_q        <= 1'b0;
      sop2_q      <= 1'b0;
      eop2_q      <= 1'b0;
      fail2_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_fail_q  <= 1'b0;
    end else begin
      v1_q        <= rden_q;
      sop1_q      <= rden_q & (idx_q == '0);
      eop1_q      <= rden_q & last_c;
      fail1_q     <= rden_q & (dfail_q | act_fail);
      v2_q        <= v1_q;
      sop2_q      <= sop1_q;
      eop2_q      <= eop1_q;
      fail2_q     <= fail1_q;
      out_valid_q <= v2_q;
      out_data_q  <= v2_q ? (q ^ (fail2_q ? '0 : mag_al)) : '0;
      out_sop_q   <= sop2_q;
      out_eop_q   <= eop2_q;
      out_fail_q  <= fail2_q;
    end
  end

  assign busy      = busy_q;
  assign rdaddress = addr_q;
  assign rden      = rden_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_fail  = out_fail_q;

endmodule

// File: tb/tb_rs_decode_corrector.sv
// Directed bench for rs_decode_corrector with a 2-cycle-latency RAM model holding i at address i.
module tb_rs_decode_corrector;
  import rs_dec_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              err_wr = 1'b0;
  logic [LOC_W-1:0]  err_loc = '0;
  logic [SYM_W-1:0]  err_mag = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              dec_fail = 1'b0;
  logic              busy;
  logic [ADDR_W-1:0] rdaddress;
  logic              rden;
  logic [SYM_W-1:0]  q = '0;
  logic              out_valid;
  logic [SYM_W-1:0]  out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_fail;

  logic [SYM_W-1:0]  mem [MEM_DEPTH];
  logic [SYM_W-1:0]  ram_s1 = '0;
  logic [7:0]        emag [2][N];
  bit                efail [2];
  int                wq_loc [$];
  logic [7:0]        wq_mag [$];
  int                n_vec = 0;
  int                n_err = 0;

  rs_decode_corrector dut (
    .clock     (clock),
    .reset     (reset),
    .err_wr    (err_wr),
    .err_loc   (err_loc),
    .err_mag   (err_mag),
    .start     (start),
    .base_addr (base_addr),
    .dec_fail  (dec_fail),
    .busy      (busy),
    .rdaddress (rdaddress),
    .rden      (rden),
    .q         (q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_fail  (out_fail)
  );

  always #5 clock = ~clock;

  // RAM: address registered at the first edge, data registered at the second.
  always @(posedge clock) begin
    if (rden) ram_s1 <= mem[rdaddress];
    q <= ram_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_exp(input int s);
    for (int k = 0; k < N; k++) emag[s][k] = 8'h00;
    efail[s] = 1'b0;
  endtask

  task automatic wr_err(input int loc, input logic [7:0] mag);
    err_wr  = 1'b1;
    err_loc = LOC_W'(loc);
    err_mag = mag;
    tick();
    err_wr  = 1'b0;
  endtask

  task automatic send_start(input int base, input bit df);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    dec_fail  = df;
    tick();
    start     = 1'b0;
    dec_fail  = 1'b0;
  endtask

  task automatic cw_head(input int base);
    chk("rden_e0", 32'(rden), 1);
    chk("addr_e0", 32'(rdaddress), 32'(base));
    chk("busy_e0", 32'(busy), 1);
    chk("vld_e0", 32'(out_valid), 0);
    for (int j = 1; j < 3; j++) begin
      tick();
      chk($sformatf("vld_lat%0d", j), 32'(out_valid), 0);
      chk($sformatf("addr_lat%0d", j), 32'(rdaddress), 32'((base + j) % MEM_DEPTH));
    end
  endtask

  // One codeword of output; optionally raises the next start on the idx N-1 cycle.
  task automatic cw_body(input int base, input int s, input bit chain, input int nbase);
    logic [31:0] exp_v;
    for (int k = 0; k < N; k++) begin
      if (wq_loc.size() > 0) begin
        err_wr  = 1'b1;
        err_loc = LOC_W'(wq_loc.pop_front());
        err_mag = wq_mag.pop_front();
      end else begin
        err_wr  = 1'b0;
      end
      start     = chain && (k == N - 3);
      base_addr = ADDR_W'(nbase);
      dec_fail  = 1'b0;
      tick();
      exp_v = {20'h0, 1'b1, (k == 0), (k == N - 1), efail[s],
               mem[(base + k) % MEM_DEPTH] ^ (efail[s] ? 8'h00 : emag[s][k])};
      chk($sformatf("sym%0d_base%0d", k, base),
          {20'h0, out_valid, out_sop, out_eop, out_fail, out_data}, exp_v);
      if (k + 3 < N)
        chk($sformatf("addr_k%0d", k), 32'(rdaddress), 32'((base + k + 3) % MEM_DEPTH));
      else if (chain)
        chk($sformatf("addr_b2b_k%0d", k), 32'(rdaddress), 32'((nbase + k + 3 - N) % MEM_DEPTH));
    end
    err_wr = 1'b0;
    start  = 1'b0;
  endtask

  task automatic cw_tail();
    tick();
    chk("vld_after", 32'(out_valid), 0);
    chk("busy_after", 32'(busy), 0);
    chk("rden_after", 32'(rden), 0);
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = SYM_W'(i);

    // Reset state
    tick();
    chk("rst_outs", {20'h0, busy, rden, out_valid, out_sop, out_eop, out_fail, out_data}, 0);
    chk("rst_addr", 32'(rdaddress), 0);
    #2 reset = 1'b0;

    // Clean codeword, base 0
    clr_exp(0);
    send_start(0, 1'b0);
    cw_head(0);
    cw_body(0, 0, 1'b0, 0);
    cw_tail();

    // Eight 0xFF errors, all corrected
    clr_exp(0);
    wr_err(0, 8'hFF);   wr_err(5, 8'hFF);   wr_err(100, 8'hFF); wr_err(203, 8'hFF);
    wr_err(1, 8'hFF);   wr_err(50, 8'hFF);  wr_err(150, 8'hFF); wr_err(202, 8'hFF);
    emag[0][0] = 8'hFF;   emag[0][5] = 8'hFF;   emag[0][100] = 8'hFF; emag[0][203] = 8'hFF;
    emag[0][1] = 8'hFF;   emag[0][50] = 8'hFF;  emag[0][150] = 8'hFF; emag[0][202] = 8'hFF;
    send_start(0, 1'b0);
    cw_head(0);
    cw_body(0, 0, 1'b0, 0);
    cw_tail();

    // Nine writes: overflow -> pass-through with out_fail
    clr_exp(0);
    wr_err(0, 8'hFF);   wr_err(5, 8'hFF);   wr_err(100, 8'hFF); wr_err(203, 8'hFF);
    wr_err(1, 8'hFF);   wr_err(50, 8'hFF);  wr_err(150, 8'hFF); wr_err(202, 8'hFF);
    wr_err(60, 8'hFF);
    efail[0] = 1'b1;
    send_start(0, 1'b0);
    cw_head(0);
    cw_body(0, 0, 1'b0, 0);
    cw_tail();

    // Address wrap from base 200
    clr_exp(0);
    send_start(200, 1'b0);
    cw_head(200);
    cw_body(200, 0, 1'b0, 0);
    cw_tail();

    // Back-to-back, second table loaded during the first read
    clr_exp(0);
    clr_exp(1);
    wr_err(3, 8'h11);
    emag[0][3] = 8'h11;
    wq_loc.push_back(3);   wq_mag.push_back(8'h22);
    wq_loc.push_back(203); wq_mag.push_back(8'h80);
    emag[1][3] = 8'h22;
    emag[1][203] = 8'h80;
    send_start(0, 1'b0);
    cw_head(0);
    cw_body(0, 0, 1'b1, 100);
    cw_body(100, 1, 1'b0, 0);
    cw_tail();

    // Duplicate location accumulates
    clr_exp(0);
    wr_err(7, 8'h0F);
    wr_err(7, 8'h03);
    emag[0][7] = 8'h0C;
    send_start(0, 1'b0);
    cw_head(0);
    cw_body(0, 0, 1'b0, 0);
    cw_tail();

    // Out-of-range location -> dropped, fail
    clr_exp(0);
    wr_err(204, 8'h5A);
    wr_err(9, 8'h01);
    efail[0] = 1'b1;
    send_start(0, 1'b0);
    cw_head(0);
    cw_body(0, 0, 1'b0, 0);
    cw_tail();

    // Decoder failure flag forces pass-through
    clr_exp(0);
    wr_err(3, 8'h11);
    efail[0] = 1'b1;
    send_start(0, 1'b1);
    cw_head(0);
    cw_body(0, 0, 1'b0, 0);
    cw_tail();

    // Async reset mid-codeword, then a clean restart with empty tables
    wr_err(10, 8'h55);
    send_start(0, 1'b0);
    cw_head(0);
    for (int j = 0; j < 48; j++) tick();
    chk("addr_idx50", 32'(rdaddress), 50);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_outs", {20'h0, busy, rden, out_valid, out_sop, out_eop, out_fail, out_data}, 0);
    chk("async_rst_addr", 32'(rdaddress), 0);
    tick();
    #2 reset = 1'b0;
    clr_exp(0);
    send_start(0, 1'b0);
    cw_head(0);
    cw_body(0, 0, 1'b0, 0);
    cw_tail();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
